// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID skid register: default widths, the bubble
// encoding and the fetch beat layout with pack/unpack helpers.
package if_id_pkg;

  localparam int          IFID_PC_W      = 8;
  localparam int          IFID_INSTR_W   = 32;
  localparam int          IFID_PC_INC    = 1;
  localparam int          IFID_CNT_W     = 16;
  localparam logic [31:0] IFID_NOP_INSTR = 32'hF800_0000;

  // One fetched beat at the default widths: PC, precomputed next-PC, instruction.
  typedef struct packed {
    logic [IFID_PC_W-1:0]    pc;
    logic [IFID_PC_W-1:0]    next_pc;
    logic [IFID_INSTR_W-1:0] instr;
  } fetch_beat_t;

  localparam int IFID_BEAT_W = $bits(fetch_beat_t);

  function automatic logic [IFID_BEAT_W-1:0] pack_beat(input fetch_beat_t b);
    return b;
  endfunction

  function automatic fetch_beat_t unpack_beat(input logic [IFID_BEAT_W-1:0] v);
    return fetch_beat_t'(v);
  endfunction

endpackage

// File: rtl/ifid_sat_counter.sv
// Saturating event counter: clears on clr, otherwise adds one per inc until
// it reaches all-ones, where it sticks.
module ifid_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on inc, hold at the maximum value, clear has priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-entry skid (main slot + skid slot),
// synchronous flush and NOP bubble output.
// Optional build macro IFID_PERF_EN adds stall/bubble/flush counters.
module if_id_skid_reg
  import if_id_pkg::*;
#(
  parameter int          PC_W      = IFID_PC_W,
  parameter int          INSTR_W   = IFID_INSTR_W,
  parameter int          PC_INC    = IFID_PC_INC,
  parameter logic [31:0] NOP_INSTR = IFID_NOP_INSTR
`ifdef IFID_PERF_EN
  ,
  parameter int          CNT_W     = IFID_CNT_W
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_next_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IFID_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  // Handshake: a beat transfers on a side exactly when valid and ready are both
  // high at a rising edge. in_ready depends only on the skid register and rst,
  // so out_ready never reaches in_ready combinationally; the skid slot absorbs
  // the one beat that may arrive while decode is stalling.

  // Same layout as fetch_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    next_pc;
    logic [INSTR_W-1:0] instr;
  } beat_t;

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  beat_t r_main;
  beat_t r_skid;
  logic  r_main_v;
  logic  r_skid_v;

  beat_t w_in_beat;
  logic  w_in_ready;
  logic  w_in_fire;
  logic  w_out_fire;
  logic  w_main_free;

  assign w_in_ready  = !r_skid_v && !rst;
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = r_main_v && out_ready;
  assign w_main_free = !r_main_v || w_out_fire;

  assign w_in_beat.pc      = in_pc;
  assign w_in_beat.next_pc = in_pc + PC_W'(PC_INC);
  assign w_in_beat.instr   = in_instr;

  // Slot update: reset, then flush, then fill/drain with skid draining first
  // so beat order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '{pc: '0, next_pc: '0, instr: NOP_W};
      r_skid   <= '{pc: '0, next_pc: '0, instr: NOP_W};
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_in_fire) begin
        r_main   <= w_in_beat;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid   <= w_in_beat;
      r_skid_v <= 1'b1;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_main_v;
  assign out_pc      = r_main.pc;
  assign out_next_pc = r_main.next_pc;
  assign out_instr   = r_main_v ? r_main.instr : NOP_W;

`ifdef IFID_PERF_EN
  logic w_stall_inc;
  logic w_bubble_inc;
  logic w_flush_inc;

  assign w_stall_inc  = r_main_v && !out_ready;
  assign w_bubble_inc = !r_main_v && out_ready;
  assign w_flush_inc  = flush && (r_main_v || r_skid_v);

  ifid_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_stall_inc),
    .cnt (stall_cnt)
  );

  ifid_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_bubble_inc),
    .cnt (bubble_cnt)
  );

  ifid_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_flush_inc),
    .cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Testbench for if_id_skid_reg. A negedge scoreboard pushes every accepted
// input beat with its expected next-PC and pops/compares on each output
// transfer; scenario tasks add targeted checks. Build with IFID_PERF_EN to
// also exercise the counters (CNT_W=4).
module tb_if_id_skid_reg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int BEAT_W  = 2 * PC_W + INSTR_W;
  localparam logic [INSTR_W-1:0] NOP = 32'hF800_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_next_pc;
  logic [INSTR_W-1:0] out_instr;
`ifdef IFID_PERF_EN
  logic [3:0]         stall_cnt;
  logic [3:0]         bubble_cnt;
  logic [3:0]         flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] exp_beat;

  // clock / reset block
  always #5 clk = ~clk;

  if_id_skid_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .PC_INC    (1),
    .NOP_INSTR (32'hF800_0000)
`ifdef IFID_PERF_EN
    ,
    .CNT_W     (4)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_next_pc (out_next_pc),
    .out_instr   (out_instr)
`ifdef IFID_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // scoreboard: queue depth equals beats held by the stage at each negedge
  always @(negedge clk) begin
    if (rst) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_in_ready_rst: got %b want 0", in_ready);
      end
      exp_q.delete();
    end else begin
      n_checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_out_valid: got %b want %0d (held %0d)", out_valid, exp_q.size() != 0, exp_q.size());
      end
      n_checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        n_fail++;
        $display("FAIL sb_in_ready: got %b want %0d (held %0d)", in_ready, exp_q.size() < 2, exp_q.size());
      end
      if (out_valid !== 1'b1) begin
        n_checks++;
        if (out_instr !== NOP) begin
          n_fail++;
          $display("FAIL sb_bubble_instr: got %h want %h", out_instr, NOP);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_beat: got pc=%h with nothing expected", out_pc);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({out_pc, out_next_pc, out_instr} !== exp_beat) begin
            n_fail++;
            $display("FAIL sb_beat: got pc=%h npc=%h instr=%h want pc=%h npc=%h instr=%h",
                     out_pc, out_next_pc, out_instr,
                     exp_beat[BEAT_W-1 -: PC_W], exp_beat[INSTR_W+PC_W-1 -: PC_W],
                     exp_beat[INSTR_W-1:0]);
          end
        end
      end
      if (flush === 1'b1) begin
        exp_q.delete();
      end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back({in_pc, in_pc + 8'd1, in_instr});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_instr !== 32'hF800_0000) begin n_fail++; $display("FAIL reset_out_instr: got %h want f8000000", out_instr); end
    n_checks++;
    if (out_pc !== 8'h00) begin n_fail++; $display("FAIL reset_out_pc: got %h want 00", out_pc); end
    n_checks++;
    if (out_next_pc !== 8'h00) begin n_fail++; $display("FAIL reset_out_next_pc: got %h want 00", out_next_pc); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_pc = 8'(i); in_instr = $urandom;
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'(i - 1) || out_next_pc !== 8'(i)) begin
          n_fail++;
          $display("FAIL stream_beat%0d: got v=%b pc=%h npc=%h want v=1 pc=%h npc=%h",
                   i - 1, out_valid, out_pc, out_next_pc, 8'(i - 1), 8'(i));
        end
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'd5) begin
      n_fail++;
      $display("FAIL stream_last: got v=%b pc=%h want v=1 pc=05", out_valid, out_pc);
    end
    step();
    step();
  endtask

  task automatic test_skid();
    logic [PC_W-1:0] pc_cur;
    logic            acc;
    pc_cur = 8'd0;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = pc_cur; in_instr = $urandom;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) out_ready = 1'b1;
      @(negedge clk);
      if (c == 4) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 8'd0) begin
          n_fail++;
          $display("FAIL skid_full: got rdy=%b v=%b pc=%h want rdy=0 v=1 pc=00", in_ready, out_valid, out_pc);
        end
      end
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        pc_cur = pc_cur + 8'd1;
        if (pc_cur == 8'd3) in_valid = 1'b0;
        else begin in_pc = pc_cur; in_instr = $urandom; end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || pc_cur != 8'd3) begin
      n_fail++;
      $display("FAIL skid_drain: got held=%0d sent=%0d want held=0 sent=3", exp_q.size(), pc_cur);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 8'hFF; in_instr = $urandom;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'hFF || out_next_pc !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_next_pc: got v=%b pc=%h npc=%h want v=1 pc=ff npc=00", out_valid, out_pc, out_next_pc);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 8'd20; in_instr = $urandom;
    step();
    in_pc = 8'd21; in_instr = $urandom;
    step();
    in_pc = 8'd22; in_instr = $urandom;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b instr=%h rdy=%b want v=0 instr=%h rdy=1", out_valid, out_instr, in_ready, NOP);
    end
    step();
    // output beat consumed on the flush cycle, input beat on that cycle dropped
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 8'd40; in_instr = $urandom;
    step();
    in_pc = 8'd41; in_instr = $urandom; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 8'd40 || out_next_pc !== 8'd41) begin
      n_fail++;
      $display("FAIL flush_in_fire: got v=%b pc=%h npc=%h want v=0 pc=28 npc=29", out_valid, out_pc, out_next_pc);
    end
    step();
    step();
  endtask

  task automatic test_random();
    logic [PC_W-1:0] seq;
    seq = 8'd100;
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_pc     = seq;
      in_instr  = $urandom;
      seq       = seq + 8'd1;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got held=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 8'd50; in_instr = $urandom;
    step();
    in_pc = 8'd51; in_instr = $urandom;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_next_pc !== 8'h00 || out_instr !== NOP) begin
      n_fail++;
      $display("FAIL midreset: got v=%b pc=%h npc=%h instr=%h want v=0 pc=00 npc=00 instr=%h",
               out_valid, out_pc, out_next_pc, out_instr, NOP);
    end
    rst = 1'b0;
    step();
  endtask

`ifdef IFID_PERF_EN
  task automatic test_perf();
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
    end
    in_valid = 1'b1; in_pc = 8'd60; in_instr = $urandom;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL perf_stall_sat: got %0d want 15", stall_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (flush_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL perf_flush: got %0d want 1", flush_cnt);
    end
    out_ready = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL perf_clear: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
    end
    rst = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_wrap();
    test_flush();
    test_random();
    test_midreset();
`ifdef IFID_PERF_EN
    test_perf();
`endif
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got held=%0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
